// File: rtl/cby_param_cfg.sv
// Vertical connection block: pass-through tracks plus NUM_IPIN configurable
// input-pin muxes, programmed through a shadow scan chain with checked commit.
//
// state | meaning
// IDLE  | no load in progress, bit counter is zero
// LOAD  | shifting bits into the shadow chain, counter tracks bits received
module cby_param_cfg #(
  parameter int CHAN_W     = 11,
  parameter int NUM_IPIN   = 2,
  parameter int MUX_SIZE   = 10,
  parameter int SEL_W      = 4,
  parameter int TAP_STRIDE = 1
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              ccff_head,
  input  logic              ccff_shift_en,
  input  logic              ccff_commit,
  input  logic [CHAN_W-1:0] chany_bottom_in,
  input  logic [CHAN_W-1:0] chany_top_in,
  output logic [CHAN_W-1:0] chany_top_out,
  output logic [CHAN_W-1:0] chany_bottom_out,
  output logic [NUM_IPIN-1:0] ipin_out,
  output logic              ccff_tail,
  output logic              cfg_valid,
  output logic              cfg_err
);

  localparam int L     = NUM_IPIN * SEL_W;
  localparam int CNT_W = $clog2(L + 2);
  localparam int SEL_N = 1 << SEL_W;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(L);
  localparam logic [CNT_W-1:0] CNT_OVR  = CNT_W'(L + 1);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t           state_q, state_nxt;
  logic [L-1:0]     chain_q, active_q;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             cfg_valid_q, cfg_err_q;
  logic             commit_ok, commit_bad;

  assign chany_top_out    = chany_bottom_in;
  assign chany_bottom_out = chany_top_in;
  assign ccff_tail        = chain_q[L-1];
  assign cfg_valid        = cfg_valid_q;
  assign cfg_err          = cfg_err_q;

  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) state_q <= IDLE;
    else               state_q <= state_nxt;
  end

  // A commit that coincides with a shift is always rejected; the shift wins.
  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = cnt_q;
    commit_ok  = 1'b0;
    commit_bad = 1'b0;
    if (ccff_shift_en) begin
      state_nxt = LOAD;
      if (cnt_q != CNT_OVR) cnt_nxt = cnt_q + 1'b1;
      commit_bad = ccff_commit;
    end else if (ccff_commit) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      if (state_q == LOAD && cnt_q == CNT_FULL) commit_ok  = 1'b1;
      else                                      commit_bad = 1'b1;
    end
  end

  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      chain_q     <= '0;
      active_q    <= '0;
      cnt_q       <= '0;
      cfg_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      if (ccff_shift_en) chain_q <= {chain_q[L-2:0], ccff_head};
      cnt_q <= cnt_nxt;
      if (commit_ok) begin
        active_q    <= chain_q;
        cfg_valid_q <= 1'b1;
        cfg_err_q   <= 1'b0;
      end else if (commit_bad) begin
        cfg_err_q <= 1'b1;
      end
    end
  end

  // Unused upper select codes read zero-padded taps, so they drive 0.
  for (genvar m = 0; m < NUM_IPIN; m++) begin : g_mux
    logic [SEL_N-1:0] taps;
    for (genvar j = 0; j < MUX_SIZE / 2; j++) begin : g_tap
      localparam int TRK = (m + j * TAP_STRIDE) % CHAN_W;
      assign taps[2*j]   = chany_bottom_in[TRK];
      assign taps[2*j+1] = chany_top_in[TRK];
    end
    if (SEL_N > MUX_SIZE) begin : g_pad
      assign taps[SEL_N-1:MUX_SIZE] = '0;
    end
    assign ipin_out[m] = cfg_valid_q & taps[active_q[m*SEL_W +: SEL_W]];
  end

endmodule
